// File: rtl/reaction_display.sv
// Reaction-time display driver: saturates the 14-bit reaction value to 9999,
// converts it to four BCD digits with a sequential double-dabble engine and
// scans a 4-digit common-anode 7-segment display with leading-zero blanking.
module reaction_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] reaction,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        busy
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t        state, state_n;
  logic          start;
  logic [13:0]   val;
  logic [13:0]   last_val;
  logic [13:0]   cap_val;
  logic [13:0]   shift_reg;
  logic [15:0]   bcd;
  logic [15:0]   bcd_adj;
  logic [3:0]    nib;
  logic [3:0]    step;
  logic          pending;
  logic [15:0]   digits;
  logic [CW-1:0] rcnt;
  logic [1:0]    idx;
  logic [3:0]    cur;
  logic          blank;
  logic [6:0]    pat;
  logic [6:0]    seg_n;

  // Clamp the incoming value to the largest four-digit number
  always_comb begin
    val = (reaction > 14'd9999) ? 14'd9999 : reaction;
  end

  // Converter next-state: start when forced or the clamped value differs
  always_comb begin
    state_n = state;
    start   = 1'b0;
    case (state)
      IDLE: begin
        if (pending || (val != last_val)) begin
          start   = 1'b1;
          state_n = CONV;
        end
      end
      CONV:    if (step == 4'd13) state_n = LOAD;
      LOAD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Double-dabble correction: add 3 to every BCD nibble of 5 or more
  always_comb begin
    bcd_adj = bcd;
    nib     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      nib = bcd[4*i +: 4];
      bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  end

  // Converter state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Converter datapath: capture, shift steps, and result load
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      bcd       <= '0;
      step      <= '0;
      pending   <= 1'b1;
      busy      <= 1'b0;
      digits    <= '0;
      last_val  <= '0;
      cap_val   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= val;
            cap_val   <= val;
            bcd       <= '0;
            step      <= '0;
            pending   <= 1'b0;
            busy      <= 1'b1;
          end
        end
        CONV: begin
          {bcd, shift_reg} <= {bcd_adj[14:0], shift_reg, 1'b0};
          step             <= step + 4'd1;
        end
        LOAD: begin
          digits   <= bcd;
          last_val <= cap_val;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Segment pattern for the digit currently selected, with leading-zero blanking
  always_comb begin
    cur   = digits[{idx, 2'b00} +: 4];
    blank = 1'b0;
    case (idx)
      2'd1:    blank = (digits[15:4] == '0);
      2'd2:    blank = (digits[15:8] == '0);
      2'd3:    blank = (digits[15:12] == '0);
      default: blank = 1'b0;
    endcase
    case (cur)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = 7'h7F;
    endcase
    seg_n = blank ? 7'h7F : pat;
  end

  // Refresh timer, scan index and registered display outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt <= '0;
      idx  <= '0;
      seg  <= 7'h7F;
      an   <= 4'hF;
    end else begin
      if (rcnt == CW'(REFRESH_DIV - 1)) begin
        rcnt <= '0;
        idx  <= idx + 2'd1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
      an  <= ~(4'b0001 << idx);
      seg <= seg_n;
    end
  end

endmodule

// File: tb/tb_reaction_display.sv
// Scoreboard bench for reaction_display: stimulus pushes expected conversions,
// a monitor checks busy length, load timing and the scanned display pattern.
module tb_reaction_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] reaction = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;

  reaction_display #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .reaction (reaction),
    .seg      (seg),
    .an       (an),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int done;
  } exp_t;

  exp_t sb[$];
  int   fall_q[$];
  int   blen_q[$];

  int total = 0;
  int bad   = 0;

  int   edge_no = 0;
  logic rst_q   = 1'b1;

  // Reference model state: converter free from this edge, last converted, forced
  int m_free    = 0;
  int m_last    = 0;
  bit m_pending = 1'b1;

  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int p10 [4] = '{1, 10, 100, 1000};

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  // Apply inputs for the upcoming edge and update the reference model
  task automatic drive_cycle(input logic [13:0] v, input logic r);
    int cyc;
    @(negedge clk);
    reaction = v;
    reset    = r;
    cyc      = edge_no;
    if (r) begin
      while (sb.size() > 0 && sb[$].done >= cyc) void'(sb.pop_back());
      m_pending = 1'b1;
      m_free    = cyc + 1;
    end else if (cyc >= m_free && (m_pending || sat(int'(v)) != m_last)) begin
      sb.push_back('{val: sat(int'(v)), done: cyc + 15});
      m_last    = sat(int'(v));
      m_pending = 1'b0;
      m_free    = cyc + 16;
    end
  endtask

  task automatic hold(input logic [13:0] v, input int n);
    for (int i = 0; i < n; i++) drive_cycle(v, 1'b0);
  endtask

  task automatic chk_blank(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_seg"}, int'(seg), 'h7F);
    chk({tag, "_an"}, int'(an), 'hF);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // Edge counter and reset value seen at each edge
  initial begin
    forever begin
      @(posedge clk);
      rst_q = reset;
      edge_no++;
    end
  end

  // Detect completed conversions (busy falling outside reset)
  initial begin
    int blen;
    blen = 0;
    forever begin
      @(negedge clk);
      if (busy) blen++;
      else begin
        if (blen > 0 && !rst_q) begin
          fall_q.push_back(edge_no - 1);
          blen_q.push_back(blen);
        end
        blen = 0;
      end
    end
  end

  // Monitor: pop expectation per completion and check one full scan rotation
  initial begin
    exp_t       e;
    int         fe, bl, p, prevp, v;
    int         cnt [4];
    logic [6:0] expseg [4];
    bit         order_ok, dwell_ok;
    forever begin
      wait (fall_q.size() > 0);
      fe = fall_q.pop_front();
      bl = blen_q.pop_front();
      chk("busy_len", bl, 15);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_conv: got completion at edge %0d expected none", fe);
      end else begin
        e = sb.pop_front();
        chk("load_edge", fe, e.done);
        v = e.val;
        for (int i = 0; i < 4; i++) begin
          if (i > 0 && v < p10[i]) expseg[i] = 7'h7F;
          else                     expseg[i] = pat[(v / p10[i]) % 10];
          cnt[i] = 0;
        end
        prevp    = -1;
        order_ok = 1'b1;
        for (int s = 0; s < 16; s++) begin
          @(negedge clk);
          case (an)
            4'b1110: p = 0;
            4'b1101: p = 1;
            4'b1011: p = 2;
            4'b0111: p = 3;
            default: p = -1;
          endcase
          total++;
          if (p < 0) begin
            bad++;
            $display("FAIL an_onehot: got %0h expected one-hot-low (value %0d)", an, v);
          end else begin
            chk($sformatf("seg_d%0d_v%0d", p, v), int'(seg), int'(expseg[p]));
            cnt[p]++;
            if (prevp >= 0 && p != prevp && p != (prevp + 1) % 4) order_ok = 1'b0;
            prevp = p;
          end
        end
        dwell_ok = (cnt[0] == 4 && cnt[1] == 4 && cnt[2] == 4 && cnt[3] == 4);
        chk("scan_dwell", int'(dwell_ok), 1);
        chk("scan_order", int'(order_ok), 1);
      end
    end
  end

  // Stimulus
  initial begin
    logic [13:0] v, prev;
    // Reset and its idle display
    drive_cycle(14'd0, 1'b1);
    drive_cycle(14'd0, 1'b1);
    chk_blank("reset");
    // Conversion forced after reset, value 0
    hold(14'd0, 40);
    hold(14'd1234, 40);
    // Saturation
    hold(14'd12000, 40);
    // Change during a conversion is picked up by the next one
    hold(14'd57, 3);
    hold(14'd305, 40);
    // Steady value does not retrigger
    hold(14'd1000, 60);
    hold(14'd999, 40);
    // Reset in the middle of a conversion
    hold(14'd4321, 8);
    drive_cycle(14'd4321, 1'b1);
    chk_blank("midreset");
    hold(14'd4321, 40);
    // Randomized segments
    prev = 14'd4321;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0:       v = 14'($urandom_range(10000, 16383));
        1:       v = 14'($urandom_range(0, 120));
        2:       v = prev;
        default: v = 14'($urandom_range(0, 9999));
      endcase
      hold(v, $urandom_range(1, 30));
      prev = v;
    end
    hold(prev, 40);
    for (int i = 0; i < 300 && (sb.size() > 0 || fall_q.size() > 0); i++) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
